// File: rtl/id_scan_arb.sv
// Round-robin arbiter that shares one identifier recognizer between two character channels.
// Optional idle timeout during streaming is enabled by defining ID_SCAN_TIMEOUT_EN.
module id_scan_arb #(
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [7:0]       req0_char,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_char,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             res_valid,
   output logic             res_src,
   output logic             res_match,
   output logic [LEN_W-1:0] res_len,
   output logic             res_abort,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_REPORT} state_t;
   typedef enum logic [1:0] {R_START, R_ALPHA, R_DIGIT} rec_t;

   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   state_t           state_q, state_d;
   rec_t             rec_q, rec_d;
   logic             grant_q, last_grant_q;
   logic [LEN_W-1:0] len_q, len_inc;
   logic             sel_valid, sel_last;
   logic [7:0]       sel_char;
   logic             accept, finish_tok, timeout_hit;

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return c >= "0" && c <= "9";
   endfunction

   always_comb begin
      sel_valid = grant_q ? req1_valid : req0_valid;
      sel_char  = grant_q ? req1_char  : req0_char;
      sel_last  = grant_q ? req1_last  : req0_last;
   end

   assign accept     = (state_q == S_STREAM) && sel_valid;
   assign finish_tok = (accept && sel_last) || timeout_hit;
   assign len_inc    = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

   // A digit only extends a match once a letter has been seen.
   always_comb begin
      rec_d = R_START;
      if (is_letter(sel_char))
         rec_d = R_ALPHA;
      else if (is_digit(sel_char) && rec_q != R_START)
         rec_d = R_DIGIT;
   end

`ifdef ID_SCAN_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_q;
   logic              abort_q;

   assign timeout_hit = (state_q == S_STREAM) && !sel_valid &&
                        (idle_q == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         idle_q <= '0;
      else if (state_q == S_STREAM && !sel_valid)
         idle_q <= idle_q + 1'b1;
      else
         idle_q <= '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         abort_q <= 1'b0;
      else if (state_q == S_STREAM && finish_tok)
         abort_q <= timeout_hit;
   end

   assign res_abort = abort_q;
`else
   assign timeout_hit = 1'b0;
   assign res_abort   = 1'b0;
`endif

   // NOTE: reset is synchronous, so it lives inside the clocked block and is
   // sampled like any other input; every register here gets a reset value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rec_q        <= R_START;
         len_q        <= '0;
         res_src      <= 1'b0;
         res_match    <= 1'b0;
         res_len      <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req0_valid || req1_valid) begin
                  grant_q <= (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
                  rec_q   <= R_START;
                  len_q   <= '0;
               end
            end
            S_STREAM: begin
               if (accept) begin
                  rec_q <= rec_d;
                  len_q <= len_inc;
               end
               // Results are captured on the closing edge so they are valid during REPORT.
               if (finish_tok) begin
                  res_src   <= grant_q;
                  res_match <= !timeout_hit && (rec_d == R_DIGIT);
                  res_len   <= accept ? len_inc : len_q;
               end
            end
            S_REPORT: last_grant_q <= grant_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req0_valid || req1_valid) state_d = S_STREAM;
         S_STREAM: if (finish_tok) state_d = S_REPORT;
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = (state_q != S_IDLE);
      res_valid  = (state_q == S_REPORT);
      if (state_q == S_STREAM) begin
         req0_ready = !grant_q;
         req1_ready = grant_q;
      end
   end

endmodule

// File: tb/tb_id_scan_arb.sv
// Self-checking bench for id_scan_arb: directed and randomized tokens against a token-level model.
// The timeout scenario is compiled in only when ID_SCAN_TIMEOUT_EN is defined.
module tb_id_scan_arb;

   localparam int LEN_W   = 4;
   localparam int LEN_MAX = (1 << LEN_W) - 1;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_last, req0_ready;
   logic [7:0]       req0_char;
   logic             req1_valid, req1_last, req1_ready;
   logic [7:0]       req1_char;
   logic             res_valid, res_src, res_match, res_abort, busy;
   logic [LEN_W-1:0] res_len;

   always #5 clk = ~clk;

   id_scan_arb #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_char  (req0_char),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_char  (req1_char),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_src    (res_src),
      .res_match  (res_match),
      .res_len    (res_len),
      .res_abort  (res_abort),
      .busy       (busy)
   );

   typedef struct {
      bit src;
      bit match;
      int len;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   bit   last_g;
   res_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_letter(input byte c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
   endfunction

   function automatic bit is_digit(input byte c);
      return c >= "0" && c <= "9";
   endfunction

   // Identifier ending in digits: non-empty trailing digit run preceded directly by a letter.
   function automatic bit model_match(input string s);
      int i = s.len() - 1;
      if (!is_digit(s[i])) return 1'b0;
      while (i >= 0 && is_digit(s[i])) i--;
      return (i >= 0) && is_letter(s[i]);
   endfunction

   function automatic int model_len(input string s);
      return (s.len() > LEN_MAX) ? LEN_MAX : s.len();
   endfunction

   task automatic push_exp(input bit src, input string s);
      res_t r;
      r.src   = src;
      r.match = model_match(s);
      r.len   = model_len(s);
      exp_q.push_back(r);
   endtask

   // Present one token per non-empty string simultaneously from IDLE and check every result.
   task automatic run(input string t0, input string t1);
      bit   has0 = (t0.len() > 0);
      bit   has1 = (t1.len() > 0);
      int   i0 = 0, i1 = 0;
      bit   s0 = 0, s1 = 0;
      bit   pulse_due = 0;
      bit   finished = 0;
      res_t r;
      if (has0 && has1) begin
         if (!last_g) begin push_exp(1'b1, t1); push_exp(1'b0, t0); last_g = 1'b0; end
         else         begin push_exp(1'b0, t0); push_exp(1'b1, t1); last_g = 1'b1; end
      end else if (has0) begin
         push_exp(1'b0, t0); last_g = 1'b0;
      end else begin
         push_exp(1'b1, t1); last_g = 1'b1;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         check("res_valid_timing", res_valid, pulse_due);
         check("ready_exclusive", req0_ready & req1_ready, 0);
         if (res_valid) begin
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check("res_src", res_src, r.src);
               check("res_match", res_match, r.match);
               check("res_len", res_len, r.len);
               check("res_abort", res_abort, 0);
            end
            if (exp_q.size() == 0) begin
               finished = 1'b1;
               break;
            end
         end
         pulse_due = 1'b0;
         if (i0 < t0.len()) begin
            req0_valid = !(s0 && $urandom_range(3) == 0);
            req0_char  = t0[i0];
            req0_last  = (i0 == t0.len() - 1);
            if (req0_valid && req0_ready) begin
               s0 = 1'b1;
               i0++;
               if (req0_last) pulse_due = 1'b1;
            end
         end else begin
            req0_valid = 1'b0;
            req0_last  = 1'b0;
         end
         if (i1 < t1.len()) begin
            req1_valid = !(s1 && $urandom_range(3) == 0);
            req1_char  = t1[i1];
            req1_last  = (i1 == t1.len() - 1);
            if (req1_valid && req1_ready) begin
               s1 = 1'b1;
               i1++;
               if (req1_last) pulse_due = 1'b1;
            end
         end else begin
            req1_valid = 1'b0;
            req1_last  = 1'b0;
         end
      end
      check("run_completed", finished, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("idle_after_report", busy, 0);
   endtask

   // Single character handshake; called at a negedge, returns at the negedge after acceptance.
   task automatic send(input bit ch, input byte c, input bit last);
      bit ok = 1'b0;
      if (ch) begin req1_valid = 1'b1; req1_char = c; req1_last = last; end
      else    begin req0_valid = 1'b1; req0_char = c; req0_last = last; end
      for (int i = 0; i < 20; i++) begin
         if ((ch ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("send_ready", ok, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   function automatic string rand_token();
      string s = "";
      int    n = $urandom_range(20, 1);
      byte   c;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(9))
            0, 1, 2, 3: c = byte'("a" + $urandom_range(25));
            4:          c = byte'("A" + $urandom_range(25));
            5, 6, 7:    c = byte'("0" + $urandom_range(9));
            8:          c = "_";
            default:    c = " ";
         endcase
         s = $sformatf("%s%c", s, c);
      end
      return s;
   endfunction

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b0; req0_char = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_char = 8'h00; req1_last = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_res_src", res_src, 0);
      check("rst_res_match", res_match, 0);
      check("rst_res_len", res_len, 0);
      check("rst_res_abort", res_abort, 0);
      rst_n  = 1'b1;
      last_g = 1'b1;

      run("ab12", "x9y");
      run("", "x9y");
      run("", "7");
      run("p4", "q7");
      run("a1234567890123456789", "");
      run("__z", "Zz0");

      for (int k = 0; k < 12; k++) begin
         case ($urandom_range(2))
            0:       run(rand_token(), "");
            1:       run("", rand_token());
            default: run(rand_token(), rand_token());
         endcase
      end

      // Reset in the middle of a channel-1 token discards it.
      send(1'b1, "a", 1'b0);
      send(1'b1, "b", 1'b0);
      check("mid_token_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_ready1", req1_ready, 0);
      check("midrst_res_len", res_len, 0);
      check("midrst_res_src", res_src, 0);
      rst_n  = 1'b1;
      last_g = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_pulse", res_valid, 0);
      end
      run("k2", "m3");

`ifdef ID_SCAN_TIMEOUT_EN
      begin
         int n = 1;
         send(1'b0, "a", 1'b0);
         send(1'b0, "b", 1'b0);
         while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("timeout_delay", n, TIMEOUT + 1);
         check("timeout_abort", res_abort, 1);
         check("timeout_match", res_match, 0);
         check("timeout_len", res_len, 2);
         check("timeout_src", res_src, 0);
         last_g = 1'b0;
         @(negedge clk);
         check("timeout_idle", busy, 0);
         run("", "w5");
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_scan_arb.md
# id_scan_arb

Round-robin controller that shares one identifier-recognition engine between two character-stream requesters. It grants one channel at a time and streams that channel's token through the recognizer until the channel flags the last character. It then issues a one-cycle result: source, match flag and token length. It sits in front of the identifier scanner in the lexer datapath, between the input byte channels and the token consumer.

## Interface
- LEN_W, 4, width of the token length counter; length saturates at 2^LEN_W-1
- TIMEOUT, 16, idle-cycle limit during streaming; used only with ID_SCAN_TIMEOUT_EN
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  synchronous, active-low reset
- req0_valid  input  1  channel 0 presents a character
- req0_char  input  8  channel 0 ASCII character
- req0_last  input  1  channel 0 character is the last of its token
- req0_ready  output  1  channel 0 character accepted this cycle when valid&ready
- req1_valid / req1_char / req1_last / req1_ready  same as channel 0, for channel 1
- res_valid  output  1  one-cycle result pulse
- res_src  output  1  channel that produced the result
- res_match  output  1  token is an identifier ending in a digit run
- res_len  output  LEN_W  accepted character count, saturating
- res_abort  output  1  token aborted by timeout; constant 0 without the macro
- busy  output  1  high in any state except IDLE

## Operation
- Controller FSM: IDLE, STREAM, REPORT.
- IDLE:
  - If any reqN_valid, grant one channel and go to STREAM.
  - If both are valid, grant the channel not granted last.
  - The last-grant register resets to 1, so channel 0 wins the first tie.
  - On grant: clear the recognizer to R_START and clear the length counter.
- STREAM:
  - reqN_ready = 1 only for the granted channel. The other ready is 0 and its inputs are ignored.
  - Each accepted character (valid&ready) advances the recognizer and increments the length counter.
  - Valid low stalls with no state change.
  - An accepted character with last=1 moves the FSM to REPORT.
- Recognizer, per accepted character. Letter = a-z or A-Z; digit = 0-9.
  - R_START: letter goes to R_ALPHA; anything else stays in R_START.
  - R_ALPHA: letter stays in R_ALPHA; digit goes to R_DIGIT; other goes to R_START.
  - R_DIGIT: letter goes to R_ALPHA; digit stays in R_DIGIT; other goes to R_START.
- REPORT:
  - res_valid = 1.
  - res_src = granted channel.
  - res_match = (recognizer == R_DIGIT), evaluated after the last character.
  - res_len = count including the last character.
  - Last-grant register updates to the granted channel. Next state is IDLE.
- Length counter: saturates at 2^LEN_W-1 and never wraps. res_match is unaffected by saturation.
- res_src, res_match and res_len are registered and hold between pulses. Consumers sample them only when res_valid = 1.
- Reset (rst_n low at a posedge), including mid-token:
  - FSM goes to IDLE and last-grant to 1.
  - All outputs go to 0.
  - A partial token is discarded with no result pulse.

## Timing
- Arbitration: valid seen in IDLE at edge N puts the FSM in STREAM at N+1, with ready high from cycle N+1.
- All ready, busy and res_* outputs are registered/Moore; there is no combinational path from inputs.
- Last character accepted at edge M: res_valid is high for cycle M+1, and the FSM is back in IDLE at M+2.
- Next grant goes out at M+2, so the earliest next ready is M+3.
- Minimum cost of a one-character token is 3 cycles.
- Throughput in STREAM is one character per cycle.
- A requester holding valid across REPORT and IDLE keeps its character; it is accepted only once ready is high.

## Configuration
- ID_SCAN_TIMEOUT_EN defined:
  - In STREAM, an idle counter counts consecutive cycles with the granted valid low, and resets on any accepted character.
  - When the count reaches TIMEOUT, go to REPORT with res_abort = 1 and res_match = 0.
  - res_len = characters accepted so far.
  - Last-grant updates as normal.
- ID_SCAN_TIMEOUT_EN undefined:
  - No idle counter; STREAM waits indefinitely.
  - res_abort is tied to 0. TIMEOUT is unused.

## Test plan
- Reset, then ch0 streams "a","b","1","2" (last on "2") → res_valid one cycle after "2" accepted, res_src=0, res_match=1, res_len=4.
- ch1 streams "x","9","y" → res_match=0, res_len=3, res_src=1. Then ch1 streams "7" alone → res_match=0, res_len=1.
- Both valid in IDLE right after reset → ch0 granted, req1_ready stays 0 throughout. The next tie grants ch1; results alternate 0,1,0.
- With LEN_W=4, ch0 streams "a" + 19 digits → res_len=15 (saturated), res_match=1.
- rst_n low for one cycle while ch1 is mid-token → no res_valid. FSM returns to IDLE with all outputs 0, and the next tie grants ch0.
- With ID_SCAN_TIMEOUT_EN and TIMEOUT=16, ch0 sends "a","b" then drops valid → res_valid 16 idle cycles later, res_abort=1, res_match=0, res_len=2.
